// File: rtl/dqn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dqn_ctrl_pkg
// Shared definitions for the DQN training sequencers.
//   state_e      : weight-update sequencer states
//   CTRL_COMMIT  : bank sel/ctrl value that commits a weight update
//   CTRL_IDLE    : bank sel/ctrl value that holds the bank
//   LAYER3/2/1   : one-hot delta-unit request codes (bit2 = L3 ... bit0 = L1)
// -----------------------------------------------------------------------------
package dqn_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_REQ3   = 4'd1,
        ST_WAIT3  = 4'd2,
        ST_REQ2   = 4'd3,
        ST_WAIT2  = 4'd4,
        ST_REQ1   = 4'd5,
        ST_WAIT1  = 4'd6,
        ST_COMMIT = 4'd7,
        ST_SYNC   = 4'd8,
        ST_DONE   = 4'd9
    } state_e;

    localparam logic [3:0] CTRL_COMMIT = 4'b1111;
    localparam logic [3:0] CTRL_IDLE   = 4'b0000;

    localparam logic [2:0] LAYER3 = 3'b100;
    localparam logic [2:0] LAYER2 = 3'b010;
    localparam logic [2:0] LAYER1 = 3'b001;
    localparam logic [2:0] LAYER_NONE = 3'b000;

endpackage

// File: rtl/dqn_wait_timer.sv
// -----------------------------------------------------------------------------
// dqn_wait_timer
// Clearable cycle counter used to bound how long a sequencer waits on a
// handshake. Counts cycles while en_i is high; expired_o is high during the
// TIMEOUT-th enabled cycle after a clear, so a caller that leaves on
// expired_o spends exactly TIMEOUT cycles waiting.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   clear_i   : restart the count (has priority over en_i)
//   en_i      : count this cycle
//   expired_o : TIMEOUT enabled cycles have been reached
// -----------------------------------------------------------------------------
module dqn_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = en_i && (cnt_q == LAST);

    // Saturates at LAST so the block stays safe if a caller keeps it enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/weight_update_seq.sv
// -----------------------------------------------------------------------------
// weight_update_seq
// Sequencer for the DQN backprop weight-update pass. Requests deltas from the
// layer 3, 2, 1 delta units in turn, then commits all three weight banks in a
// single cycle, counts commits and pulses target_sync every SYNC_PERIOD commits.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin one pass (accepted only in IDLE)
//   abort                : cancel the pass before commit
//   delta_valid          : requested delta unit has valid, held outputs
//   delta_start[2:0]     : one-hot layer request (bit2 = L3)
//   sel1..3 / ctrl1..3   : bank controls, 4'b1111 only in COMMIT
//   busy                 : not IDLE
//   done                 : one-cycle pass-complete pulse
//   target_sync          : one-cycle target-network copy pulse
//   err                  : sticky wait-timeout flag, cleared by accepted start
//   update_count         : completed commits, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module weight_update_seq
    import dqn_ctrl_pkg::*;
#(
    parameter int SYNC_PERIOD = 16,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             delta_valid,
    output logic [2:0]       delta_start,
    output logic [3:0]       sel3,
    output logic [3:0]       ctrl3,
    output logic [3:0]       sel2,
    output logic [3:0]       ctrl2,
    output logic [3:0]       sel1,
    output logic [3:0]       ctrl1,
    output logic             busy,
    output logic             done,
    output logic             target_sync,
    output logic             err,
    output logic [CNT_W-1:0] update_count
);

    localparam int SW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]     sync_q, sync_d;

    logic              in_wait;
    logic              expired;

    assign in_wait = (state_q == ST_WAIT3) || (state_q == ST_WAIT2) ||
                     (state_q == ST_WAIT1);

    // Every WAITx is entered from its REQx, so holding the timer clear outside
    // the wait states restarts it on each entry.
    dqn_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!in_wait),
        .en_i      (in_wait),
        .expired_o (expired)
    );

    // Next state and counters. Priority inside a wait: abort, then
    // delta_valid, then timeout (a late delta_valid still wins the race).
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        sync_d  = sync_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_REQ3;
                    err_d   = 1'b0;
                end
            end
            ST_REQ3: state_d = abort ? ST_IDLE : ST_WAIT3;
            ST_REQ2: state_d = abort ? ST_IDLE : ST_WAIT2;
            ST_REQ1: state_d = abort ? ST_IDLE : ST_WAIT1;
            ST_WAIT3, ST_WAIT2, ST_WAIT1: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (delta_valid) begin
                    case (state_q)
                        ST_WAIT3: state_d = ST_REQ2;
                        ST_WAIT2: state_d = ST_REQ1;
                        default:  state_d = ST_COMMIT;
                    endcase
                end else if (expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_COMMIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sync_q == SYNC_LAST) begin
                    sync_d  = '0;
                    state_d = ST_SYNC;
                end else begin
                    sync_d  = sync_q + SW'(1);
                    state_d = ST_DONE;
                end
            end
            ST_SYNC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
        end
    end

    // Moore outputs decoded from the registered state only, so an asynchronous
    // reset drops the bank controls in the same instant.
    always_comb begin
        delta_start = LAYER_NONE;
        sel3        = CTRL_IDLE;
        ctrl3       = CTRL_IDLE;
        sel2        = CTRL_IDLE;
        ctrl2       = CTRL_IDLE;
        sel1        = CTRL_IDLE;
        ctrl1       = CTRL_IDLE;
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        target_sync = (state_q == ST_SYNC);

        case (state_q)
            ST_REQ3: delta_start = LAYER3;
            ST_REQ2: delta_start = LAYER2;
            ST_REQ1: delta_start = LAYER1;
            ST_COMMIT: begin
                sel3  = CTRL_COMMIT;
                ctrl3 = CTRL_COMMIT;
                sel2  = CTRL_COMMIT;
                ctrl2 = CTRL_COMMIT;
                sel1  = CTRL_COMMIT;
                ctrl1 = CTRL_COMMIT;
            end
            default: ;
        endcase
    end

    assign err          = err_q;
    assign update_count = cnt_q;

endmodule

// File: tb/tb_weight_update_seq.sv
module tb_weight_update_seq;

    localparam int SP  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic delta_valid = 1'b0;

    logic [2:0]  ds_a, ds_b;
    logic [3:0]  s3a, c3a, s2a, c2a, s1a, c1a;
    logic [3:0]  s3b, c3b, s2b, c2b, s1b, c1b;
    logic        busy_a, done_a, sync_a, err_a;
    logic        busy_b, done_b, sync_b, err_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    weight_update_seq #(.SYNC_PERIOD(SP), .TIMEOUT(TMO), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .delta_valid(delta_valid), .delta_start(ds_a),
        .sel3(s3a), .ctrl3(c3a), .sel2(s2a), .ctrl2(c2a), .sel1(s1a), .ctrl1(c1a),
        .busy(busy_a), .done(done_a), .target_sync(sync_a), .err(err_a),
        .update_count(cnt_a));

    weight_update_seq #(.SYNC_PERIOD(SP), .TIMEOUT(TMO), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .delta_valid(delta_valid), .delta_start(ds_b),
        .sel3(s3b), .ctrl3(c3b), .sel2(s2b), .ctrl2(c2b), .sel1(s1b), .ctrl1(c1b),
        .busy(busy_b), .done(done_b), .target_sync(sync_b), .err(err_b),
        .update_count(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 requesting a layer, 2 waiting on that layer,
    // 3 committing, 4 syncing, 5 done
    int m_ph, m_layer, m_wait, m_cnt, m_since;
    bit m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = 0; m_layer = 3; m_wait = 0; m_cnt = 0; m_since = 0; m_err = 0;
        end else begin
            case (m_ph)
                0: if (start && !abort) begin m_ph = 1; m_layer = 3; m_err = 0; end
                1: if (abort) m_ph = 0; else begin m_ph = 2; m_wait = 0; end
                2: begin
                    if (abort) m_ph = 0;
                    else if (delta_valid) begin
                        if (m_layer == 1) m_ph = 3;
                        else begin m_layer = m_layer - 1; m_ph = 1; end
                    end else begin
                        m_wait = m_wait + 1;
                        if (m_wait >= TMO) begin m_err = 1; m_ph = 0; end
                    end
                end
                3: begin
                    m_cnt = m_cnt + 1;
                    m_since = m_since + 1;
                    if (m_since == SP) begin m_since = 0; m_ph = 4; end
                    else m_ph = 5;
                end
                4: m_ph = 5;
                default: m_ph = 0;
            endcase
        end
    end

    function automatic logic [2:0] e_ds();
        return (m_ph == 1) ? (3'b001 << (m_layer - 1)) : 3'b000;
    endfunction

    function automatic logic [23:0] e_bank();
        return (m_ph == 3) ? 24'hFFFFFF : 24'h000000;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("delta_start", {29'd0, ds_a}, {29'd0, e_ds()});
            chk("bank_ctrl", {8'd0, s3a, c3a, s2a, c2a, s1a, c1a}, {8'd0, e_bank()});
            chk("busy", {31'd0, busy_a}, {31'd0, m_ph != 0});
            chk("done", {31'd0, done_a}, {31'd0, m_ph == 5});
            chk("target_sync", {31'd0, sync_a}, {31'd0, m_ph == 4});
            chk("err", {31'd0, err_a}, {31'd0, m_err});
            chk("update_count", {16'd0, cnt_a}, m_cnt & 32'hFFFF);
            chk("update_count_w4", {28'd0, cnt_b}, m_cnt & 32'hF);
            chk("w4_outputs", {3'd0, ds_b, s3b, c3b, s2b, c2b, s1b, c1b, busy_b, done_b, sync_b, err_b},
                {3'd0, e_ds(), e_bank(), m_ph != 0, m_ph == 5, m_ph == 4, m_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        #2 rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; delta_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One pass with delta_valid held high; a stray start mid-pass is issued.
    task automatic run_pass(output bit s_sync, output bit s_commit, output bit s_done);
        int n;
        s_sync = 0; s_commit = 0; s_done = 0;
        start = 1'b1; delta_valid = 1'b1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (sync_a) s_sync = 1;
            if (s1a == 4'hF) s_commit = 1;
            if (done_a) begin s_done = 1; break; end
        end
        start = 1'b0;
        if (!s_done) chk("pass_bound", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 40; n++) begin
            if (!busy_a) break;
            @(negedge clk);
        end
        if (busy_a) chk(name, 32'd1, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit sy, cm, dn;
        int c, base;
        logic [2:0] ds_tbl [10];
        ds_tbl[0] = 3'b100; ds_tbl[1] = 3'b000; ds_tbl[2] = 3'b010; ds_tbl[3] = 3'b000;
        ds_tbl[4] = 3'b001; ds_tbl[5] = 3'b000; ds_tbl[6] = 3'b000; ds_tbl[7] = 3'b000;
        ds_tbl[8] = 3'b000; ds_tbl[9] = 3'b000;

        @(negedge clk);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_bank", {8'd0, s3a, c3a, s2a, c2a, s1a, c1a}, 32'd0);
        chk("rst_count", {16'd0, cnt_a}, 32'd0);
        chk("rst_ds", {29'd0, ds_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Single pass, delta answered in the first cycle of every wait.
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            delta_valid = (n == 1 || n == 3 || n == 5);
            chk($sformatf("lit_ds_%0d", n), {29'd0, ds_a}, {29'd0, ds_tbl[n]});
            chk($sformatf("lit_commit_%0d", n), {28'd0, s2a}, (n == 6) ? 32'hF : 32'h0);
            chk($sformatf("lit_done_%0d", n), {31'd0, done_a}, {31'd0, n == 7});
            chk($sformatf("lit_busy_%0d", n), {31'd0, busy_a}, {31'd0, n <= 7});
        end
        chk("lit_count_1", {16'd0, cnt_a}, 32'd1);

        // Sync cadence and 4-bit wrap over 17 passes from reset.
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            run_pass(sy, cm, dn);
            chk($sformatf("lit_sync_pass%0d", p), {31'd0, sy}, {31'd0, p == 16});
            chk($sformatf("lit_commit_pass%0d", p), {31'd0, cm}, 32'd1);
        end
        chk("lit_count_17", {16'd0, cnt_a}, 32'd17);
        chk("lit_count_w4_17", {28'd0, cnt_b}, 32'd1);

        // Timeout in WAIT2.
        start = 1'b1; delta_valid = 1'b1;
        for (c = 0; c < 20 && ds_a != 3'b010; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        delta_valid = 1'b0;
        cm = 0;
        for (c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s1a == 4'hF) cm = 1;
            if (!busy_a) break;
        end
        chk("lit_tmo_cycles", c + 1, 32'd9);
        chk("lit_tmo_err", {31'd0, err_a}, 32'd1);
        chk("lit_tmo_nocommit", {31'd0, cm}, 32'd0);
        chk("lit_tmo_count", {16'd0, cnt_a}, 32'd17);
        start = 1'b1; delta_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lit_err_cleared", {31'd0, err_a}, 32'd0);
        wait_idle("idle_bound_a");
        chk("lit_count_18", {16'd0, cnt_a}, 32'd18);

        // Abort in WAIT1.
        @(negedge clk);
        start = 1'b1; delta_valid = 1'b1;
        for (c = 0; c < 20 && ds_a != 3'b001; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        delta_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("lit_abort_idle", {31'd0, busy_a}, 32'd0);
        chk("lit_abort_count", {16'd0, cnt_a}, 32'd18);

        // Abort during COMMIT is ignored.
        start = 1'b1; delta_valid = 1'b1;
        for (c = 0; c < 20 && s3a != 4'hF; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("lit_abort_commit_done", {31'd0, done_a}, 32'd1);
        chk("lit_abort_commit_count", {16'd0, cnt_a}, 32'd19);
        @(negedge clk);

        // Reset during WAIT3 and during COMMIT.
        start = 1'b1; delta_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("lit_in_wait3", {28'd0, busy_a, ds_a}, 32'h8);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("lit_rst_count", {16'd0, cnt_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; delta_valid = 1'b1;
        for (c = 0; c < 20 && s3a != 4'hF; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_bank", {8'd0, s3a, c3a, s2a, c2a, s1a, c1a}, 32'd0);
        chk("lit_rst_done", {30'd0, done_a, sync_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int e = 0; e < 20; e++) begin
            int dvp;
            dvp = (e % 4 == 3) ? 12 : 2;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                start = ($urandom % 4) == 0;
                abort = ($urandom % 40) == 0;
                delta_valid = ($urandom % dvp) == 0;
            end
        end
        start = 1'b0; abort = 1'b0; delta_valid = 1'b0;
        repeat (20) @(negedge clk);
        base = checks;
        chk("random_ran", (base > 1000) ? 32'd1 : 32'd0, 32'd1);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
